// File: rtl/pipeline_ctrl_pkg.sv
// ============================================================================
// Module   : pipeline_pkg
// Purpose  : Shared types and constants for the five-stage pipeline controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

    localparam int STATE_W     = 3;
    localparam int FLUSH_CNT_W = 4;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EXE = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_FLUSH  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
// ============================================================================
// Module   : pipeline_ctrl_if
// Purpose  : Handshake bundle between the pipeline controller and the stages.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipeline_ctrl_if;
    import pipeline_pkg::*;

    logic                IF_over;
    logic                ID_over;
    logic                EXE_over;
    logic                MEM_over;
    logic                WB_over;
    logic                cancel;
    logic                halt_req;
    logic                resume;

    logic                IF_valid;
    logic                ID_valid;
    logic                EXE_valid;
    logic                MEM_valid;
    logic                WB_valid;
    logic                next_fetch;
    logic                IF_ID_en;
    logic                ID_EXE_en;
    logic                EXE_MEM_en;
    logic                MEM_WB_en;
    logic                halted;
    logic [STATE_W-1:0]  state;

    modport master (
        input  IF_over, ID_over, EXE_over, MEM_over, WB_over,
        input  cancel, halt_req, resume,
        output IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid,
        output next_fetch, IF_ID_en, ID_EXE_en, EXE_MEM_en, MEM_WB_en,
        output halted, state
    );

    modport slave (
        output IF_over, ID_over, EXE_over, MEM_over, WB_over,
        output cancel, halt_req, resume,
        input  IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid,
        input  next_fetch, IF_ID_en, ID_EXE_en, EXE_MEM_en, MEM_WB_en,
        input  halted, state
    );

endinterface

`default_nettype wire

// File: rtl/pipeline_ctrl_slot.sv
// ============================================================================
// Module   : pipe_stage_slot
// Purpose  : One stage valid flop with its allow-in term.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_slot (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic in_fire_i,
    input  wire logic over_i,
    input  wire logic next_allow_i,
    input  wire logic flush_i,
    output logic      valid_o,
    output logic      allow_o
);

    logic valid_q;
    logic valid_d;

    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (in_fire_i) begin
            valid_d = 1'b1;
        end else if (valid_q && over_i && next_allow_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign valid_o = valid_q;
    assign allow_o = ~valid_q | (over_i & next_allow_i);

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// ============================================================================
// Module   : pipeline_ctrl
// Purpose  : Valid/allow-in sequencing, cancel flush and drain/halt control
//            for the IF-ID-EXE-MEM-WB pipeline. Optional performance counters
//            are enabled with `define PIPE_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  wire logic         clk,
    input  wire logic         reset,
    pipeline_ctrl_if.master   bus
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic [CNT_W-1:0]  id_stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15 || CNT_W < 1) begin : g_param_check
        $error("pipeline_ctrl: FLUSH_CYCLES must be 1..15 and CNT_W >= 1");
    end

    localparam logic [FLUSH_CNT_W-1:0] C_FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);

    state_e                  state_q, state_d;
    logic [FLUSH_CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic                    if_valid_q, if_valid_d;

    logic                    w_flush_now;
    logic                    w_next_fetch;
    logic                    w_if_allow, w_id_allow, w_exe_allow, w_mem_allow, w_wb_allow;
    logic                    w_id_valid, w_exe_valid, w_mem_valid, w_wb_valid;
    logic                    w_if_id_en, w_id_exe_en, w_exe_mem_en, w_mem_wb_en;
    logic [4:0]              w_valid;

    assign w_flush_now = bus.cancel & w_wb_valid;

    // The cancelling instruction lives in WB, so MEM->WB is never squashed.
    assign w_if_allow   = ~if_valid_q | (bus.IF_over & w_id_allow);
    assign w_if_id_en   = if_valid_q  & bus.IF_over  & w_id_allow  & ~w_flush_now;
    assign w_id_exe_en  = w_id_valid  & bus.ID_over  & w_exe_allow & ~w_flush_now;
    assign w_exe_mem_en = w_exe_valid & bus.EXE_over & w_mem_allow & ~w_flush_now;
    assign w_mem_wb_en  = w_mem_valid & bus.MEM_over & w_wb_allow;

    assign w_next_fetch = (state_q == ST_RUN) & w_if_allow & ~w_flush_now;

    pipe_stage_slot u_id_slot (
        .clk(clk), .reset(reset), .in_fire_i(w_if_id_en), .over_i(bus.ID_over),
        .next_allow_i(w_exe_allow), .flush_i(w_flush_now),
        .valid_o(w_id_valid), .allow_o(w_id_allow)
    );

    pipe_stage_slot u_exe_slot (
        .clk(clk), .reset(reset), .in_fire_i(w_id_exe_en), .over_i(bus.EXE_over),
        .next_allow_i(w_mem_allow), .flush_i(w_flush_now),
        .valid_o(w_exe_valid), .allow_o(w_exe_allow)
    );

    pipe_stage_slot u_mem_slot (
        .clk(clk), .reset(reset), .in_fire_i(w_exe_mem_en), .over_i(bus.MEM_over),
        .next_allow_i(w_wb_allow), .flush_i(w_flush_now),
        .valid_o(w_mem_valid), .allow_o(w_mem_allow)
    );

    pipe_stage_slot u_wb_slot (
        .clk(clk), .reset(reset), .in_fire_i(w_mem_wb_en), .over_i(bus.WB_over),
        .next_allow_i(1'b1), .flush_i(1'b0),
        .valid_o(w_wb_valid), .allow_o(w_wb_allow)
    );

    always_comb begin
        if_valid_d = if_valid_q;
        if (w_flush_now) begin
            if_valid_d = 1'b0;
        end else if (w_next_fetch) begin
            if_valid_d = 1'b1;
        end else if (w_if_id_en) begin
            if_valid_d = 1'b0;
        end
    end

    assign w_valid[STG_IF]  = if_valid_q;
    assign w_valid[STG_ID]  = w_id_valid;
    assign w_valid[STG_EXE] = w_exe_valid;
    assign w_valid[STG_MEM] = w_mem_valid;
    assign w_valid[STG_WB]  = w_wb_valid;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN: begin
                if (w_flush_now) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = C_FLUSH_LOAD;
                end else if (bus.halt_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FLUSH: begin
                if (w_flush_now) begin
                    flush_cnt_d = C_FLUSH_LOAD;
                end else begin
                    // Leave on the cycle the counter reaches zero.
                    flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
                    if (flush_cnt_q <= FLUSH_CNT_W'(1)) begin
                        flush_cnt_d = '0;
                        state_d     = bus.halt_req ? ST_DRAIN : ST_RUN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_flush_now) begin
                    state_d = ST_DRAIN;
                end else if (w_valid == 5'b0) begin
                    state_d = ST_HALTED;
                end else if (!bus.halt_req) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (bus.resume) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
            if_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            if_valid_q  <= if_valid_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] retire_cnt_q, id_stall_cnt_q, flush_cnt_perf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_cnt_q     <= '0;
            id_stall_cnt_q   <= '0;
            flush_cnt_perf_q <= '0;
        end else begin
            if (w_wb_valid && bus.WB_over) retire_cnt_q     <= retire_cnt_q + CNT_W'(1);
            if (w_id_valid && !bus.ID_over) id_stall_cnt_q  <= id_stall_cnt_q + CNT_W'(1);
            if (w_flush_now)                flush_cnt_perf_q <= flush_cnt_perf_q + CNT_W'(1);
        end
    end

    assign retire_cnt   = retire_cnt_q;
    assign id_stall_cnt = id_stall_cnt_q;
    assign flush_cnt    = flush_cnt_perf_q;
`endif

    assign bus.IF_valid   = if_valid_q;
    assign bus.ID_valid   = w_id_valid;
    assign bus.EXE_valid  = w_exe_valid;
    assign bus.MEM_valid  = w_mem_valid;
    assign bus.WB_valid   = w_wb_valid;
    assign bus.next_fetch = w_next_fetch;
    assign bus.IF_ID_en   = w_if_id_en;
    assign bus.ID_EXE_en  = w_id_exe_en;
    assign bus.EXE_MEM_en = w_exe_mem_en;
    assign bus.MEM_WB_en  = w_mem_wb_en;
    assign bus.halted     = (state_q == ST_HALTED);
    assign bus.state      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
// Module   : tb_pipeline_ctrl
// Purpose  : Directed plus random stimulus against a stage-array reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;

    localparam int FLUSH_N = 2;
    localparam int CNT_W   = 32;

    localparam int S_IDLE = 0, S_RUN = 1, S_FLUSH = 2, S_DRAIN = 3, S_HALTED = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pipeline_ctrl_if bus();

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] retire_cnt, id_stall_cnt, flush_cnt;
`endif

    pipeline_ctrl #(.FLUSH_CYCLES(FLUSH_N), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef PIPE_PERF_CNT_EN
        ,
        .retire_cnt(retire_cnt),
        .id_stall_cnt(id_stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Stimulus, index 0 = IF ... 4 = WB
    bit        ov [5];
    bit        cancel_in, halt_in, resume_in;

    // Reference model: one valid bit per stage plus controller mode
    bit [4:0]  mv;
    int        mstate, mrem;
    bit [31:0] m_retire, m_stall, m_flush;
    bit        mallow [5];
    bit [3:0]  men;
    bit        mflush, mnf;

    task automatic model_reset();
        mv = '0; mstate = S_IDLE; mrem = 0;
        m_retire = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_comb();
        mflush    = cancel_in && mv[4];
        mallow[4] = !mv[4] || ov[4];
        for (int s = 3; s >= 0; s--) mallow[s] = !mv[s] || (ov[s] && mallow[s+1]);
        for (int s = 0; s < 4; s++)
            men[s] = mv[s] && ov[s] && mallow[s+1] && (s == 3 || !mflush);
        mnf = (mstate == S_RUN) && mallow[0] && !mflush;
    endtask

    task automatic model_step();
        bit [4:0] nv;
        bit       done;
        nv = mv;
        for (int s = 1; s < 5; s++) begin
            done = mv[s] && ov[s] && (s == 4 || mallow[s+1]);
            if (mflush && s < 4) nv[s] = 1'b0;
            else if (men[s-1])   nv[s] = 1'b1;
            else if (done)       nv[s] = 1'b0;
        end
        if (mflush)      nv[0] = 1'b0;
        else if (mnf)    nv[0] = 1'b1;
        else if (men[0]) nv[0] = 1'b0;
        if (mv[4] && ov[4])  m_retire++;
        if (mv[1] && !ov[1]) m_stall++;
        if (mflush)          m_flush++;
        case (mstate)
            S_IDLE: mstate = S_RUN;
            S_RUN: begin
                if (mflush) begin mstate = S_FLUSH; mrem = FLUSH_N; end
                else if (halt_in) mstate = S_DRAIN;
            end
            S_FLUSH: begin
                if (mflush) mrem = FLUSH_N;
                else begin
                    mrem--;
                    if (mrem == 0) mstate = halt_in ? S_DRAIN : S_RUN;
                end
            end
            S_DRAIN: begin
                if (mflush) mstate = S_DRAIN;
                else if (mv == 0) mstate = S_HALTED;
                else if (!halt_in) mstate = S_RUN;
            end
            S_HALTED: if (resume_in) mstate = S_RUN;
            default: mstate = S_IDLE;
        endcase
        mv = nv;
    endtask

    task automatic drive();
        bus.IF_over  = ov[0];
        bus.ID_over  = ov[1];
        bus.EXE_over = ov[2];
        bus.MEM_over = ov[3];
        bus.WB_over  = ov[4];
        bus.cancel   = cancel_in;
        bus.halt_req = halt_in;
        bus.resume   = resume_in;
    endtask

    // One clock: drive, compare against the model, advance both.
    task automatic cyc();
        drive();
        #1;
        model_comb();
        check_eq("valid", {bus.WB_valid, bus.MEM_valid, bus.EXE_valid, bus.ID_valid, bus.IF_valid}, mv);
        check_eq("en", {bus.MEM_WB_en, bus.EXE_MEM_en, bus.ID_EXE_en, bus.IF_ID_en}, men);
        check_eq("next_fetch", bus.next_fetch, mnf);
        check_eq("halted", bus.halted, mstate == S_HALTED);
        check_eq("state", bus.state, mstate);
`ifdef PIPE_PERF_CNT_EN
        check_eq("retire_cnt", retire_cnt, m_retire);
        check_eq("id_stall_cnt", id_stall_cnt, m_stall);
        check_eq("flush_cnt", flush_cnt, m_flush);
`endif
        @(posedge clk);
        if (!reset) model_step();
        @(negedge clk);
    endtask

    task automatic all_over();
        for (int s = 0; s < 5; s++) ov[s] = 1'b1;
    endtask

    initial begin
        bit reached;
        all_over();
        cancel_in = 0; halt_in = 0; resume_in = 0;
        model_reset();
        drive();
        @(negedge clk);
        cyc(); cyc();

        // Fill from reset; a cancel at k=3 finds WB empty and must be ignored.
        reset = 1'b0;
        for (int k = 0; k < 9; k++) begin
            cancel_in = (k == 3);
            if (k == 5) check_eq("fill_wb_k5", bus.WB_valid, 1'b0);
            if (k == 6) check_eq("fill_wb_k6", bus.WB_valid, 1'b1);
            cyc();
        end
        cancel_in = 0;

        // ID stall for three cycles
        ov[1] = 1'b0;
        repeat (3) cyc();
        ov[1] = 1'b1;
        repeat (4) cyc();

        // Cancel with a full pipeline
        cancel_in = 1'b1;
        cyc();
        cancel_in = 1'b0;
        check_eq("cancel_state", bus.state, S_FLUSH);
        repeat (8) cyc();

        // Drain with EXE held busy for four cycles
        halt_in = 1'b1;
        ov[2]   = 1'b0;
        repeat (4) cyc();
        ov[2]   = 1'b1;
        reached = 1'b0;
        for (int k = 0; k < 50 && !reached; k++) begin
            if (bus.halted) reached = 1'b1;
            else cyc();
        end
        check_eq("halt_reached", reached, 1'b1);
        cyc();
        halt_in   = 1'b0;
        resume_in = 1'b1;
        cyc();
        resume_in = 1'b0;
        repeat (3) cyc();

        // Fill, then halt with EXE stuck, then reset asynchronously mid-drain
        repeat (6) cyc();
        halt_in = 1'b1;
        ov[2]   = 1'b0;
        repeat (3) cyc();
        check_eq("drain_before_rst", bus.state, S_DRAIN);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_valid", {bus.WB_valid, bus.MEM_valid, bus.EXE_valid, bus.ID_valid, bus.IF_valid}, 5'b0);
        check_eq("arst_en", {bus.MEM_WB_en, bus.EXE_MEM_en, bus.ID_EXE_en, bus.IF_ID_en}, 4'b0);
        check_eq("arst_next_fetch", bus.next_fetch, 1'b0);
        check_eq("arst_halted", bus.halted, 1'b0);
        check_eq("arst_state", bus.state, S_IDLE);
        model_reset();
        cyc();
        halt_in = 1'b0;
        all_over();
        reset = 1'b0;

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            for (int s = 0; s < 5; s++) ov[s] = ($urandom_range(0, 3) != 0);
            cancel_in = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 29) == 0) halt_in = !halt_in;
            resume_in = ($urandom_range(0, 7) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
